// File: rtl/seq_stream_detector_ctrl_if.sv
// Word/result handshake bundle for seq_stream_detector_ctrl.
// master: word producer and result consumer. slave: the controller.
interface seq_stream_detector_ctrl_if #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 5
) ();
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count
    );
endinterface

// File: rtl/seq_stream_detector_ctrl.sv
// Word-to-bit serializer feeding an overlapping sequence detector with a
// runtime-programmable pattern. The match count per word is returned over
// a valid/ready result handshake.
// Optional macro SEQ_CARRY_EN: history carries across words, so matches may
// span word boundaries (credited to the word holding their final bit).
module seq_stream_detector_ctrl #(
    parameter int               WORD_W  = 16,
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 5,
    parameter logic [PAT_W-1:0] DEF_PAT = 4'b1011
) (
    input  logic                       clk,
    input  logic                       reset,
    seq_stream_detector_ctrl_if.slave  bus,
    input  logic                       cfg_we,
    input  logic [PAT_W-1:0]           cfg_pattern,
    output logic                       serial_bit,
    output logic                       match_pulse,
    output logic                       busy
);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    logic [1:0]        state;
    logic [PAT_W-1:0]  pattern;
    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  hist_next;
    logic [IDX_W-1:0]  bit_idx;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  count;
    logic              qualified;
    logic              match;
    logic              last_bit;
`ifdef SEQ_CARRY_EN
    logic              first_word;
`endif

    // Next history value and match decision for the bit being consumed.
    always_comb begin
        hist_next = {hist[PAT_W-2:0], shreg[WORD_W-1]};
        last_bit  = (bit_idx == IDX_W'(WORD_W - 1));
`ifdef SEQ_CARRY_EN
        // Only the first word after reset can start with a partial history.
        qualified = !first_word || (bit_idx >= IDX_W'(PAT_W - 1));
`else
        qualified = (bit_idx >= IDX_W'(PAT_W - 1));
`endif
        match     = (state == ST_SHIFT) && qualified && (hist_next == pattern);
    end

    // Controller state, serializer, history and match counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pattern     <= DEF_PAT;
            hist        <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            count       <= '0;
            serial_bit  <= 1'b0;
            match_pulse <= 1'b0;
`ifdef SEQ_CARRY_EN
            first_word  <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    match_pulse <= 1'b0;
                    if (cfg_we) begin
                        pattern <= cfg_pattern;
                    end
                    if (bus.in_valid) begin
                        shreg   <= bus.in_data;
                        count   <= '0;
                        bit_idx <= '0;
`ifndef SEQ_CARRY_EN
                        hist    <= '0;
`endif
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shreg       <= shreg << 1;
                    hist        <= hist_next;
                    serial_bit  <= shreg[WORD_W-1];
                    bit_idx     <= bit_idx + IDX_W'(1);
                    match_pulse <= match;
                    if (match) begin
                        count <= count + CNT_W'(1);
                    end
                    if (last_bit) begin
                        state <= ST_REPORT;
`ifdef SEQ_CARRY_EN
                        first_word <= 1'b0;
`endif
                    end
                end
                ST_REPORT: begin
                    match_pulse <= 1'b0;
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_REPORT);
        bus.out_count = count;
        busy          = (state != ST_IDLE);
    end
endmodule
